// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - display-side bundle for the seven-segment scan driver
//
// Ports (bundled signals):
//   value      [4*NUM_DIGITS] packed hex nibbles, nibble i is digit i (digit 0 rightmost)
//   load                      capture value/blank_mask/dp_mask into the driver shadows
//   blank_mask [NUM_DIGITS]   1 = force digit dark
//   dp_mask    [NUM_DIGITS]   1 = light decimal point of digit
//   seg        [7]            segments, active-low, bit0=a .. bit6=g
//   dp                        decimal point, active-low
//   an         [NUM_DIGITS]   digit enables, active-low
// Modports: master = register side driving the display, slave = scan driver.

interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output value, load, blank_mask, dp_mask,
        input  seg, dp, an
    );

    modport slave (
        input  value, load, blank_mask, dp_mask,
        output seg, dp, an
    );
endinterface

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed common-anode seven-segment scan driver
//
// Latches a packed hex value plus blank/dp masks into shadow registers and
// scans one digit per REFRESH_DIV-cycle slot, with DEAD_CYCLES of all-anodes-off
// at the start of each slot to stop ghosting between digits.
//
// Parameters:
//   NUM_DIGITS  (1..8)   digits scanned
//   REFRESH_DIV (>=2)    clock cycles per digit slot
//   DEAD_CYCLES (<REFRESH_DIV) leading dark cycles per slot
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    seven_seg_scan_if.slave (value, load, blank_mask, dp_mask in; seg, dp, an out)
// Optional feature:
//   SEVEN_SEG_SCAN_LZ_SUPPRESS_EN - when defined, leading zero digits (above
//   digit 0) are darkened in addition to blank_mask.

module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    seven_seg_scan_if.slave      bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_V   = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_DARK = 7'h7F;

    // Shadow copies: the display never looks at the raw inputs.
    logic [4*NUM_DIGITS-1:0] value_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;

    // Scan position.
    logic [CNT_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        digit_idx;

    // Registered pin drivers.
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;

    // Next-cycle pin values derived from the current scan/shadow state.
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic                    digit_dark;
    logic                    in_dead;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h18;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] = value_sh[4*i +: 4];
        end
    end

`ifdef SEVEN_SEG_SCAN_LZ_SUPPRESS_EN
    // Walk down from the most significant digit; a digit is suppressed while
    // every nibble from it upward is zero. Digit 0 always stays lit.
    logic all_zero;

    always_comb begin
        lz_dark  = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero & (nib[i] == 4'h0);
            lz_dark[i] = all_zero;
        end
    end
`else
    assign lz_dark = '0;
`endif

    always_comb begin
        digit_dark = blank_sh[digit_idx] | lz_dark[digit_idx];
        in_dead    = (DEAD_CYCLES != 0) && (div_cnt < DEAD_V);

        seg_d = SEG_DARK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (!in_dead) begin
            // Anode stays enabled even for a dark digit so the scan duty is uniform.
            an_d = ~(NUM_DIGITS'(1) << digit_idx);
            if (!digit_dark) begin
                seg_d = glyph(nib[digit_idx]);
                dp_d  = ~dp_sh[digit_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_sh  <= '0;
            blank_sh  <= '0;
            dp_sh     <= '0;
            div_cnt   <= '0;
            digit_idx <= '0;
            seg_q     <= SEG_DARK;
            dp_q      <= 1'b1;
            an_q      <= '1;
        end else begin
            if (bus.load) begin
                value_sh <= bus.value;
                blank_sh <= bus.blank_mask;
                dp_sh    <= bus.dp_mask;
            end

            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (digit_idx == IDX_LAST) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.an  = an_q;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for a bank of common-anode seven-segment digits on the ALU lab board. It latches a packed hex value, scans one digit at a time at a programmable refresh rate, and drives shared active-low segment lines and active-low digit enables. It renders the full 0–F glyph set and supports per-digit blanking, decimal points and anti-ghosting dead time. It sits between the ALU result/status registers and the board pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned (1–8)
- REFRESH_DIV, 50000: clock cycles per digit slot (≥ 2)
- DEAD_CYCLES, 1: cycles at the start of each slot with all anodes off (0 ≤ DEAD_CYCLES < REFRESH_DIV)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  packed hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost
- load  in  1  capture value, blank_mask and dp_mask into shadow registers
- blank_mask  in  NUM_DIGITS  1 = force digit dark
- dp_mask  in  NUM_DIGITS  1 = light decimal point of digit
- seg  out  7  segments, active-low, bit0=a … bit6=g
- dp  out  1  decimal point, active-low
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-low while lit

## Operation
- Shadow registers (value, blank, dp) load on `load`; display shows only shadow contents, never raw inputs.
- Slot counter div_cnt counts 0..REFRESH_DIV-1; at terminal count it wraps to 0 and digit_idx advances 0→1→…→NUM_DIGITS-1→0.
- Glyph (seg[6:0], hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E; dark = 7F.
- Digit dark if shadow blank bit set (or suppressed, see Configuration): seg=7F, dp=1, an bit still asserted.
- dp = ~shadow_dp[digit_idx] unless digit dark.
- Dead time: while div_cnt < DEAD_CYCLES, an = all 1s, seg=7F, dp=1.
- Otherwise an = all 1s except bit digit_idx = 0.

## Timing
- All outputs registered; outputs reflect the div_cnt/digit_idx/shadow state of the previous cycle (1-cycle latency).
- Reset (synchronous): shadows 0, div_cnt 0, digit_idx 0; seg=7F, dp=1, an all 1s on the cycle after reset is sampled high.
- First lit output after reset release: digit 0 showing glyph of shadow (0 → 40), after DEAD_CYCLES+1 cycles.
- load at cycle t: shadow updated at t+1 edge; outputs change at t+2. Scan counters are unaffected by load.
- load coincident with slot wrap: new digit uses new shadow one cycle later; no glitch beyond that one-cycle window is permitted.
- reset mid-scan: overrides load and counters; scan restarts at digit 0, div_cnt 0.
- NUM_DIGITS=1: digit_idx stays 0; dead time still applied every REFRESH_DIV cycles.
- Full frame period = NUM_DIGITS*REFRESH_DIV cycles.

## Configuration
- Macro SEVEN_SEG_SCAN_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression. Digit i (i ≥ 1) is dark when shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed. Suppression is combined by OR with blank_mask. The dp of a suppressed digit is also dark.
- Undefined: all digits show their nibble; only blank_mask darkens. The suppression logic is absent from the netlist.

## Test plan
- Reset: hold reset 3 cycles, NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1 -> seg=7F, an=1111, dp=1 during reset and one cycle after; then an=1110, seg=40.
- Glyph sweep: load value=0x0000..0xFFFF stepping digit 0 through 0–F -> seg on digit-0 slot matches table (e.g. A→08, d→21, F→0E).
- Scan order: load 0x12AF, REFRESH_DIV=4 -> lit sequence an=1110/seg=0E, 1101/08, 1011/24, 0111/79. Each slot has 1 dead cycle with an=1111, and the frame repeats every 16 cycles.
- Blank/dp: load 0x1234, blank_mask=0100, dp_mask=0001 -> digit 2 seg=7F; digit 0 seg=19, dp=0; others dp=1.
- LZ suppression (macro defined): load 0x0070 -> digits 3,2 dark; digit 1 seg=78; digit 0 seg=40. Load 0x0000 -> only digit 0 lit (40). With macro undefined, 0x0070 shows 40,40,78,40.
- Reset mid-scan: assert reset during digit 2 slot after load 0x5555 -> next output dark; after release scan resumes at digit 0 with seg=40 (shadow cleared).
